// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: a two-entry store queue that drains ahead of
// loads, a single-outstanding memory request port with a wait-cycle timeout,
// and a registered load-complete handshake (DMdone) for the stall unit.
module dm_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_Ld,
    input  logic        is_St,
    input  logic        pipe_stall,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        DMdone,
    output logic [31:0] ld_data,
    output logic        st_full,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_BUSY = 2'd1,
        LD_BUSY = 2'd2,
        LD_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_q_addr [2];
    logic [31:0] r_q_data [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic [7:0]  r_wait;

    logic        w_enq;
    logic        w_pop;
    logic        w_tail;
    logic        w_tmo;
    logic        w_busy;

    // A load in the same slot as a store wins; the store is never queued.
    assign st_full = (r_count == 2'd2);
    assign w_enq   = is_St && !is_Ld && !pipe_stall && !st_full;
    assign w_tail  = r_head ^ (r_count == 2'd1);
    assign w_busy  = (r_state == ST_BUSY) || (r_state == LD_BUSY);
    assign w_tmo   = w_busy && !mem_ack && (r_wait == 8'(TIMEOUT - 1));
    assign w_pop   = (r_state == ST_BUSY) && (mem_ack || w_tmo);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state: queued stores always drain before a pending load issues.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_count != 2'd0) w_next = ST_BUSY;
                else if (is_Ld)      w_next = LD_BUSY;
            end
            ST_BUSY: if (mem_ack || w_tmo) w_next = IDLE;
            LD_BUSY: if (mem_ack || w_tmo) w_next = LD_DONE;
            LD_DONE: if (!pipe_stall)      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Store queue pointers/occupancy; simultaneous push and pop keeps count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_pop) r_head <= ~r_head;
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Store queue payload; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_addr[w_tail] <= dm_addr;
            r_q_data[w_tail] <= dm_wdata;
        end
    end

    // Wait counter: zero outside busy states, counts unacknowledged busy cycles.
    always_ff @(posedge clk) begin
        if (reset)                  r_wait <= '0;
        else if (w_busy && !mem_ack && !w_tmo) r_wait <= r_wait + 8'd1;
        else                        r_wait <= '0;
    end

    // Registered memory-port and pipeline outputs, updated on state transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            DMdone    <= 1'b0;
            ld_data   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_count != 2'd0) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= r_q_addr[r_head];
                        mem_wdata <= r_q_data[r_head];
                    end else if (is_Ld) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= dm_addr;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack || w_tmo) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                    if (w_tmo) bus_err <= 1'b1;
                end
                LD_BUSY: begin
                    if (mem_ack) begin
                        ld_data <= mem_rdata;
                        DMdone  <= 1'b1;
                        mem_req <= 1'b0;
                    end else if (w_tmo) begin
                        ld_data <= '0;
                        DMdone  <= 1'b1;
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                    end
                end
                LD_DONE: begin
                    if (!pipe_stall) DMdone <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl. Inputs change #1 after a rising edge and
// outputs are sampled there, so a value "after edge k" is what the pipeline
// sees at edge k+1.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        is_Ld;
    logic        is_St;
    logic        pipe_stall;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        DMdone;
    logic [31:0] ld_data;
    logic        st_full;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;
    int req_cnt;

    dm_access_ctrl #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .is_Ld     (is_Ld),
        .is_St     (is_St),
        .pipe_stall(pipe_stall),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .DMdone    (DMdone),
        .ld_data   (ld_data),
        .st_full   (st_full),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".DMdone"},    {31'd0, DMdone},  32'd0);
        chk({tag, ".ld_data"},   ld_data,          32'd0);
        chk({tag, ".mem_req"},   {31'd0, mem_req}, 32'd0);
        chk({tag, ".mem_we"},    {31'd0, mem_we},  32'd0);
        chk({tag, ".mem_addr"},  mem_addr,         32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata,        32'd0);
        chk({tag, ".bus_err"},   {31'd0, bus_err}, 32'd0);
        chk({tag, ".st_full"},   {31'd0, st_full}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; is_Ld = 1'b0; is_St = 1'b0; pipe_stall = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        chk_zero_outputs("reset");
        reset = 1'b0;
        tick();

        // Load at 0x40, ack in first request cycle.
        is_Ld = 1'b1; dm_addr = 32'h40; mem_rdata = 32'hDEADBEEF;
        tick();                                   // edge N
        chk("ld.req",    {31'd0, mem_req}, 32'd1);
        chk("ld.we",     {31'd0, mem_we},  32'd0);
        chk("ld.addr",   mem_addr,         32'h40);
        chk("ld.done0",  {31'd0, DMdone},  32'd0);
        mem_ack = 1'b1;
        tick();                                   // edge N+1, seen at N+2
        mem_ack = 1'b0;
        chk("ld.done1",  {31'd0, DMdone},  32'd1);
        chk("ld.data",   ld_data,          32'hDEADBEEF);
        chk("ld.reqoff", {31'd0, mem_req}, 32'd0);
        tick();
        is_Ld = 1'b0;
        chk("ld.done_clr", {31'd0, DMdone}, 32'd0);
        tick();
        chk("ld.noreissue", {31'd0, mem_req}, 32'd0);

        // Back-to-back stores, ack delayed 3 cycles, third store held by st_full.
        is_St = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hA0;
        tick();                                   // E1 enqueue 0x10
        chk("st.full1", {31'd0, st_full}, 32'd0);
        chk("st.req1",  {31'd0, mem_req}, 32'd0);
        dm_addr = 32'h14; dm_wdata = 32'hA1;
        tick();                                   // E2 issue 0x10, enqueue 0x14
        chk("st.full2", {31'd0, st_full}, 32'd1);
        chk("st.req2",  {31'd0, mem_req}, 32'd1);
        chk("st.we2",   {31'd0, mem_we},  32'd1);
        chk("st.addr2", mem_addr,         32'h10);
        chk("st.data2", mem_wdata,        32'hA0);
        dm_addr = 32'h18; dm_wdata = 32'hA2;
        tick();                                   // E3
        chk("st.hold3", mem_addr, 32'h10);
        chk("st.full3", {31'd0, st_full}, 32'd1);
        tick();                                   // E4
        tick();                                   // E5
        chk("st.hold5", mem_addr,         32'h10);
        chk("st.req5",  {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        tick();                                   // E6 pop 0x10
        mem_ack = 1'b0;
        chk("st.req6",  {31'd0, mem_req}, 32'd0);
        chk("st.full6", {31'd0, st_full}, 32'd0);
        tick();                                   // E7 issue 0x14, enqueue 0x18
        is_St = 1'b0;
        chk("st.addr7", mem_addr,         32'h14);
        chk("st.data7", mem_wdata,        32'hA1);
        chk("st.full7", {31'd0, st_full}, 32'd1);
        mem_ack = 1'b1;
        tick();                                   // E8 pop 0x14
        mem_ack = 1'b0;
        chk("st.req8",  {31'd0, mem_req}, 32'd0);
        tick();                                   // E9 issue 0x18
        chk("st.addr9", mem_addr,  32'h18);
        chk("st.data9", mem_wdata, 32'hA2);
        mem_ack = 1'b1;
        tick();                                   // E10 pop 0x18
        mem_ack = 1'b0;
        tick();
        chk("st.empty", {31'd0, mem_req}, 32'd0);
        chk("st.err",   {31'd0, bus_err}, 32'd0);

        // Store then load to the same address: write first, DMdone only after read.
        is_St = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h55;
        tick();
        is_St = 1'b0; is_Ld = 1'b1;
        tick();
        chk("sl.we",    {31'd0, mem_we},  32'd1);
        chk("sl.waddr", mem_addr,         32'h20);
        chk("sl.wdata", mem_wdata,        32'h55);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sl.gap",   {31'd0, mem_req}, 32'd0);
        chk("sl.done0", {31'd0, DMdone},  32'd0);
        tick();
        chk("sl.rreq",  {31'd0, mem_req}, 32'd1);
        chk("sl.rwe",   {31'd0, mem_we},  32'd0);
        mem_rdata = 32'h12345678;
        tick();
        chk("sl.done1", {31'd0, DMdone},  32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sl.done2", {31'd0, DMdone}, 32'd1);
        chk("sl.data",  ld_data,         32'h12345678);
        tick();
        is_Ld = 1'b0;

        // pipe_stall held for 5 cycles in LD_DONE.
        is_Ld = 1'b1; dm_addr = 32'h80; mem_rdata = 32'hCAFEF00D;
        req_cnt = 0;
        tick();
        if (mem_req) req_cnt++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; pipe_stall = 1'b1;
        chk("stall.done", {31'd0, DMdone}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_req) req_cnt++;
            chk("stall.held", {31'd0, DMdone}, 32'd1);
        end
        pipe_stall = 1'b0;
        tick();
        if (mem_req) req_cnt++;
        chk("stall.release", {31'd0, DMdone}, 32'd0);
        is_Ld = 1'b0;
        tick();
        if (mem_req) req_cnt++;
        chk("stall.reqs", req_cnt, 32'd1);

        // Load timeout with TIMEOUT=4: abort after 4 unacknowledged cycles.
        is_Ld = 1'b1; dm_addr = 32'h90;
        tick();
        chk("to.req", {31'd0, mem_req}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to.wait", {31'd0, DMdone}, 32'd0);
        end
        chk("to.err0", {31'd0, bus_err}, 32'd0);
        tick();
        chk("to.done",  {31'd0, DMdone},  32'd1);
        chk("to.data",  ld_data,          32'h0);
        chk("to.err1",  {31'd0, bus_err}, 32'd1);
        chk("to.reqoff",{31'd0, mem_req}, 32'd0);
        tick();
        is_Ld = 1'b0;
        chk("to.done_clr", {31'd0, DMdone}, 32'd0);
        // Stray ack while idle must not touch ld_data.
        mem_rdata = 32'h11111111; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stray.data", ld_data,          32'h0);
        chk("to.sticky",  {31'd0, bus_err}, 32'd1);

        // Load and store together: treated as a load, store dropped.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        is_Ld = 1'b1; is_St = 1'b1; dm_addr = 32'hB0; dm_wdata = 32'h99; mem_rdata = 32'h0000BBBB;
        tick();
        chk("both.we",   {31'd0, mem_we},  32'd0);
        chk("both.full", {31'd0, st_full}, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("both.data", ld_data, 32'h0000BBBB);
        tick();
        is_Ld = 1'b0; is_St = 1'b0;
        tick();
        chk("both.nostore", {31'd0, mem_req}, 32'd0);

        // Reset during LD_BUSY, late ack discarded.
        is_Ld = 1'b1; dm_addr = 32'hA0; mem_rdata = 32'h77777777;
        tick();
        chk("rst.req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        chk_zero_outputs("rst.mid");
        reset = 1'b0; is_Ld = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rst.data", ld_data,          32'h0);
        chk("rst.done", {31'd0, DMdone},  32'd0);
        chk("rst.req2", {31'd0, mem_req}, 32'd0);
        tick();
        chk("rst.idle", {31'd0, mem_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
